uart_comm: RTL and testbench



---
 rtl/uart_comm_pkg.sv | 17 +
 rtl/uart_comm_uart.sv | 157 +++++++++++++++
 rtl/uart_comm.sv | 88 ++++++++
 tb/tb_uart_comm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_comm_pkg.sv
// Shared types and constants for the serial command front end.
// Holds the TX/RX/assembler state encodings and frame geometry.
package uart_pkg;

  localparam int FRAME_BITS       = 10;
  localparam int DATA_BITS        = 8;
  localparam int BAUD_DIV_DEFAULT = 2604;

  typedef enum logic {TX_IDLE = 1'b0, TX_XMIT = 1'b1} tx_state_e;
  typedef enum logic {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_e;
  typedef enum logic [1:0] {
    BYTE_HI  = 2'd0,
    BYTE_MID = 2'd1,
    BYTE_LO  = 2'd2
  } cmd_state_e;

endpackage

// File: rtl/uart_comm_uart.sv
// Full-duplex 8N1 UART: independent TX and RX halves sharing only the clock.
// RX samples mid-bit after a 2-flop synchronizer; rx_start marks entry into RECV.
module uart
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_start
);

  localparam int CW = $clog2(BAUD_DIV);

  tx_state_e              tx_state_q, tx_state_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
  logic [3:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS:0]     tx_shift_q, tx_shift_d;
  logic                   tx_q, tx_d;
  logic                   tx_done_q, tx_done_d;

  rx_state_e              rx_state_q, rx_state_d;
  logic                   rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [3:0]             rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_rdy_q, rx_rdy_d;
  logic                   rx_start_q, rx_start_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= '1;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= '0;
      rx_rdy_q   <= 1'b0;
      rx_start_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
      rx_state_q <= rx_state_d;
      rx_sync1_q <= RX;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_start_q <= rx_start_d;
    end
  end

  // Shift register carries data then the stop bit; the start bit is driven on acceptance.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_done_d  = tx_done_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (trmt) begin
          tx_state_d = TX_XMIT;
          tx_shift_d = {1'b1, tx_data};
          tx_cnt_d   = '0;
          tx_bit_d   = 4'd0;
          tx_d       = 1'b0;
          tx_done_d  = 1'b0;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_XMIT: begin
        if (tx_cnt_q == CW'(BAUD_DIV - 1)) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'(FRAME_BITS - 1)) begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
            tx_done_d  = 1'b1;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[DATA_BITS:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Start bit is shifted in too and pushed out by the 8 data bits; stop sample only ends the frame.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_rdy_d   = 1'b0;
    rx_start_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d = RX_RECV;
          rx_cnt_d   = CW'(BAUD_DIV / 2 - 1);
          rx_bit_d   = 4'd0;
          rx_start_d = 1'b1;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_RECV: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d = CW'(BAUD_DIV - 1);
          if (rx_bit_q == 4'(FRAME_BITS - 1)) begin
            rx_state_d = RX_IDLE;
            rx_rdy_d   = 1'b1;
          end else begin
            rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
            rx_bit_d   = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign TX       = tx_q;
  assign tx_done  = tx_done_q;
  assign rx_data  = rx_shift_q;
  assign rx_rdy   = rx_rdy_q;
  assign rx_start = rx_start_q;

endmodule

// File: rtl/uart_comm.sv
// Serial command front end: UART plus an assembler packing three received
// bytes, MSB byte first, into a 24-bit command word.
module uart_comm
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic        trmt,
  input  logic [7:0]  tx_data,
  input  logic        clr_cmd_rdy,
  output logic        TX,
  output logic        tx_done,
  output logic [23:0] cmd,
  output logic        cmd_rdy
);

  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rx_start;
  cmd_state_e  state_q, state_d;
  logic [23:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;

  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_done (tx_done),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .rx_start(rx_start)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BYTE_HI;
      cmd_q     <= 24'h000000;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // Completion of the low byte takes priority over any clear in the same cycle.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (rx_rdy) begin
      case (state_q)
        BYTE_HI: begin
          cmd_d[23:16] = rx_data;
          state_d      = BYTE_MID;
        end
        BYTE_MID: begin
          cmd_d[15:8] = rx_data;
          state_d     = BYTE_LO;
        end
        BYTE_LO: begin
          cmd_d[7:0] = rx_data;
          state_d    = BYTE_HI;
        end
        default: state_d = BYTE_HI;
      endcase
    end else begin
      state_d = state_q;
    end
    if (rx_rdy && (state_q == BYTE_LO)) begin
      cmd_rdy_d = 1'b1;
    end else if (clr_cmd_rdy || rx_start) begin
      cmd_rdy_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_q;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_uart_comm.sv
// Loopback bench for uart_comm at BAUD_DIV=16: expected commands are queued
// as they are sent and a monitor compares them on each cmd_rdy rise.
module tb_uart_comm;
  import uart_pkg::*;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        serial;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        clr_cmd_rdy;
  logic        tx_done;
  logic [23:0] cmd;
  logic        cmd_rdy;

  int checks = 0;
  int errors = 0;
  logic [23:0] sb[$];
  logic rdy_prev = 1'b0;
  logic rxr_prev = 1'b0;

  uart_comm #(.BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (serial),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .clr_cmd_rdy(clr_cmd_rdy),
    .TX         (serial),
    .tx_done    (tx_done),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one byte over the loopback; extra_at>0 re-pulses trmt at that cycle offset.
  task automatic send(input logic [7:0] b, input int extra_at);
    int n;
    trmt = 1'b1;
    tx_data = b;
    tick(1);
    trmt = 1'b0;
    check("tx_start_low", {31'd0, serial}, 32'd0);
    check("tx_done_clr", {31'd0, tx_done}, 32'd0);
    n = 0;
    while (!tx_done && n < 400) begin
      if (extra_at > 0 && n == extra_at) begin
        trmt = 1'b1;
        tx_data = ~b;
      end else begin
        trmt = 1'b0;
      end
      tick(1);
      n++;
    end
    trmt = 1'b0;
    check("tx_done_latency", n, 32'd160);
  endtask

  // Scoreboard monitor: every cmd_rdy rise consumes one expected command.
  always @(negedge clk) begin
    if (!rst && cmd_rdy && !rdy_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=cmd_rdy_rise cmd=%0h expected=no_rise", cmd);
      end else begin
        check("cmd_word", {8'd0, cmd}, {8'd0, sb.pop_front()});
        check("rdy_after_rx_rdy", {31'd0, rxr_prev}, 32'd1);
      end
    end
    rdy_prev <= cmd_rdy;
    rxr_prev <= dut.u_uart.rx_rdy;
  end

  initial begin
    logic bad;
    logic got;
    rst = 1'b1;
    trmt = 1'b0;
    tx_data = 8'h00;
    clr_cmd_rdy = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_tx", {31'd0, serial}, 32'd1);
    check("rst_tx_done", {31'd0, tx_done}, 32'd0);
    check("rst_cmd", {8'd0, cmd}, 32'd0);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);

    // Three back-to-back bytes
    sb.push_back(24'h55AAE3);
    send(8'h55, 0);
    send(8'hAA, 0);
    send(8'hE3, 0);
    tick(2);
    check("t1_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

    // Clear, then a new first byte keeps cmd_rdy low
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    check("t2_clr", {31'd0, cmd_rdy}, 32'd0);
    check("t2_cmd_hold", {8'd0, cmd}, 32'h0055AAE3);
    bad = 1'b0;
    fork
      send(8'h12, 0);
      begin
        repeat (165) begin
          tick(1);
          if (cmd_rdy) bad = 1'b1;
        end
      end
    join
    check("t2_rdy_stays_low", {31'd0, bad}, 32'd0);
    check("t2_cmd_hi", {24'd0, cmd[23:16]}, 32'h12);
    check("t2_cmd_lo", {16'd0, cmd[15:0]}, 32'hAAE3);

    // Reset with trmt pulsed during it
    rst = 1'b1;
    trmt = 1'b1;
    tx_data = 8'hC3;
    tick(1);
    check("t3_tx", {31'd0, serial}, 32'd1);
    check("t3_tx_done", {31'd0, tx_done}, 32'd0);
    trmt = 1'b0;
    tick(1);
    check("t3_cmd", {8'd0, cmd}, 32'd0);
    check("t3_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    rst = 1'b0;
    tick(2);
    check("t3_asm_idle", {30'd0, dut.state_q}, {30'd0, BYTE_HI});
    check("t3_tx_idle", {31'd0, dut.u_uart.tx_state_q}, {31'd0, TX_IDLE});
    check("t3_rx_idle", {31'd0, dut.u_uart.rx_state_q}, {31'd0, RX_IDLE});
    bad = 1'b0;
    repeat (40) begin
      tick(1);
      if (!serial || tx_done) bad = 1'b1;
    end
    check("t3_line_quiet", {31'd0, bad}, 32'd0);

    // Partial command discarded by reset mid third frame
    send(8'h01, 0);
    send(8'h02, 0);
    trmt = 1'b1;
    tx_data = 8'h77;
    tick(1);
    trmt = 1'b0;
    tick(80);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    check("t4_cmd_cleared", {8'd0, cmd}, 32'd0);
    sb.push_back(24'hA55A0F);
    send(8'hA5, 0);
    send(8'h5A, 0);
    send(8'h0F, 0);
    tick(2);
    check("t4_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

    // Mid-frame trmt ignored; trmt on the tx_done edge ignored
    send(8'h3C, 60);
    bad = 1'b0;
    repeat (3 * BD) begin
      tick(1);
      if (!serial) bad = 1'b1;
    end
    check("t5_no_second_frame", {31'd0, bad}, 32'd0);
    send(8'h81, 159);

    // clr_cmd_rdy coinciding with third-byte completion: set wins
    sb.push_back(24'h3C8142);
    got = 1'b0;
    fork
      send(8'h42, 0);
      begin
        for (int i = 0; i < 200 && !got; i++) begin
          tick(1);
          if (dut.u_uart.rx_rdy) begin
            clr_cmd_rdy = 1'b1;
            tick(1);
            clr_cmd_rdy = 1'b0;
            got = 1'b1;
          end
        end
      end
    join
    check("t6_clr_window", {31'd0, got}, 32'd1);
    tick(2);
    check("t6_set_wins", {31'd0, cmd_rdy}, 32'd1);

    // A new start bit clears cmd_rdy
    send(8'h9D, 0);
    check("t7_start_clears", {31'd0, cmd_rdy}, 32'd0);
    check("t7_cmd", {8'd0, cmd}, 32'h009D8142);

    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
